joy_answer_encoder: RTL

JOY_ANSWER_ENCODER -- requirements
Module: joy_answer_encoder

---
 rtl/joy_pkg.sv | 44 ++++
 rtl/joy_answer_encoder_debounce.sv | 51 +++++
 rtl/joy_answer_encoder.sv | 110 +++++++++++
 3 files changed

// File: rtl/joy_pkg.sv
// Shared definitions for the joystick answer encoder:
// vector width, FSM states, vector classes and encoding helpers.
package joy_pkg;

    localparam int JOY_W = 9;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        WAIT_REL
    } state_t;

    typedef enum logic [1:0] {
        CLS_REL,
        CLS_SINGLE,
        CLS_MULTI
    } cls_t;

    function automatic logic [3:0] onehot_to_value(
        input logic [JOY_W-1:0] oh
    );
        logic [3:0] v;
        v = '0;
        for (int i = 0; i < JOY_W; i++) begin
            if (oh[i]) v = 4'(i + 1);
        end
        return v;
    endfunction

    // Clearing the lowest set bit leaves something only if two or more were set.
    function automatic cls_t classify(
        input logic [JOY_W-1:0] vec
    );
        cls_t c;
        if (vec == '0)
            c = CLS_REL;
        else if ((vec & (vec - JOY_W'(1))) != '0)
            c = CLS_MULTI;
        else
            c = CLS_SINGLE;
        return c;
    endfunction

endpackage

// File: rtl/joy_answer_encoder_debounce.sv
// Per-player two-flop synchronizer, hold counter and stable vector register.
// Also flags the cycle after the stable vector turns multi-hot.
module joy_debounce
    import joy_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [JOY_W-1:0] raw,
    output logic [JOY_W-1:0] stable,
    output logic             multi_rise
);

    localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0] CNT_DONE = 4'(DEBOUNCE_CYCLES);

    logic [JOY_W-1:0] sync1;
    logic [JOY_W-1:0] sync2;
    logic [3:0]       cnt;
    logic             load;
    logic             enter_multi;

    // sync1 differing from sync2 means sync2 changes on this edge.
    assign load = (sync1 == sync2) && (cnt == CNT_LAST);

    assign enter_multi = load
                      && (classify(sync2) == CLS_MULTI)
                      && (classify(stable) != CLS_MULTI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= '0;
            sync2      <= '0;
            cnt        <= '0;
            stable     <= '0;
            multi_rise <= 1'b0;
        end else begin
            sync1      <= raw;
            sync2      <= sync1;
            if (sync1 != sync2)
                cnt <= '0;
            else if (cnt != CNT_DONE)
                cnt <= cnt + 4'd1;
            if (load)
                stable <= sync2;
            multi_rise <= enter_multi;
        end
    end

endmodule

// File: rtl/joy_answer_encoder.sv
// Two-player joystick answer encoder: debounces both sticks, arbitrates
// single-key presses and presents one answer at a time over valid/ready.
module joy_answer_encoder
    import joy_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [JOY_W-1:0] joy_left_raw,
    input  logic [JOY_W-1:0] joy_right_raw,
    input  logic             ans_ready,
    output logic             ans_valid,
    output logic             ans_player,
    output logic [JOY_W-1:0] ans_onehot,
    output logic [3:0]       ans_value,
    output logic             err_multi
);

    logic [JOY_W-1:0] left_stable;
    logic [JOY_W-1:0] right_stable;
    logic             left_rise;
    logic             right_rise;

    joy_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_left (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw        (joy_left_raw),
        .stable     (left_stable),
        .multi_rise (left_rise)
    );

    joy_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_right (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw        (joy_right_raw),
        .stable     (right_stable),
        .multi_rise (right_rise)
    );

    state_t           state;
    state_t           state_nx;
    logic             prio;
    logic             prio_nx;
    logic             player_nx;
    logic [JOY_W-1:0] onehot_nx;
    logic             grant_right;
    logic             left_single;
    logic             right_single;
    logic             both_rel;

    assign left_single  = classify(left_stable) == CLS_SINGLE;
    assign right_single = classify(right_stable) == CLS_SINGLE;
    assign both_rel     = (left_stable == '0) && (right_stable == '0);

    // prio = 1 hands a tie to the right player.
    always_comb begin
        state_nx    = state;
        prio_nx     = prio;
        player_nx   = ans_player;
        onehot_nx   = ans_onehot;
        grant_right = 1'b0;
        unique case (state)
            IDLE: begin
                if (left_single || right_single) begin
                    grant_right = right_single && (!left_single || prio);
                    player_nx   = grant_right;
                    onehot_nx   = grant_right ? right_stable : left_stable;
                    state_nx    = HOLD;
                end
            end
            HOLD: begin
                if (ans_ready) begin
                    prio_nx   = ~ans_player;
                    onehot_nx = '0;
                    state_nx  = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (both_rel)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            prio       <= 1'b0;
            ans_player <= 1'b0;
            ans_onehot <= '0;
            ans_value  <= '0;
        end else begin
            state      <= state_nx;
            prio       <= prio_nx;
            ans_player <= player_nx;
            ans_onehot <= onehot_nx;
            ans_value  <= onehot_to_value(onehot_nx);
        end
    end

    assign ans_valid = (state == HOLD);
    assign err_multi = left_rise | right_rise;

endmodule
